fetch_pc_gen: RTL and testbench



---
 rtl/fetch_pkg.sv | 13 +
 rtl/pred_fifo.sv | 62 ++++++
 rtl/fetch_pc_gen.sv | 113 +++++++++++
 tb/tb_fetch_pc_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch next-PC generator.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_rec_t;

endpackage

// File: rtl/pred_fifo.sv
// Synchronous FIFO of prediction records; head is read straight from storage.
module pred_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  pred_rec_t         i_data,
  output pred_rec_t         o_head,
  output logic [PTR_BITS:0] o_count,
  output logic              o_full,
  output logic              o_empty
);

  pred_rec_t             r_mem [DEPTH];
  logic [PTR_BITS-1:0]   r_wr_ptr;
  logic [PTR_BITS-1:0]   r_rd_ptr;
  logic [PTR_BITS:0]     r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_count == (PTR_BITS+1)'(DEPTH));
  assign o_empty = (r_count == {(PTR_BITS+1){1'b0}});
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Record storage; stale entries are harmless since pointers govern validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking; flush empties the queue like reset.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= {PTR_BITS{1'b0}};
      r_rd_ptr <= {PTR_BITS{1'b0}};
      r_count  <= {(PTR_BITS+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_BITS+1)'(1);
        2'b01:   r_count <= r_count - (PTR_BITS+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch next-PC generator: queues predictions and checks them against EX.
// Optional macro FETCH_PC_CHECK_EN enables the sticky protocol error flag err_o.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          PRED_DEPTH = 4,
  parameter int          PTR_BITS   = $clog2(PRED_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       pc_f_o,
  output logic              fetch_valid_o,
  input  logic              fetch_ready_i,
  input  logic              predict_taken_i,
  input  logic [31:0]       predict_target_i,
  input  logic              ex_valid_i,
  input  logic [31:0]       ex_pc_i,
  input  logic              ex_taken_i,
  input  logic [31:0]       ex_target_i,
  output logic              mispredict_o,
  output logic [31:0]       redirect_pc_o,
  output logic [PTR_BITS:0] pred_count_o,
  output logic              err_o
);

  logic [31:0] r_pc;
  pred_rec_t   w_head;
  pred_rec_t   w_push_rec;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_resolve;
  logic [31:0] w_head_seq;
  logic [31:0] w_pred_next;
  logic [31:0] w_actual_next;
  logic        w_mispredict;

  assign pc_f_o        = r_pc;
  assign fetch_valid_o = !w_full;
  assign w_accept      = fetch_valid_o && fetch_ready_i;
  assign w_resolve     = ex_valid_i && !w_empty;
  assign w_push_rec    = '{pc: r_pc, taken: predict_taken_i, target: predict_target_i};

  pred_fifo #(
    .DEPTH    (PRED_DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_pred_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept && !w_mispredict),
    .i_pop   (w_resolve),
    .i_flush (w_mispredict),
    .i_data  (w_push_rec),
    .o_head  (w_head),
    .o_count (pred_count_o),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Compare predicted and actual successor of the head record.
  always_comb begin
    w_head_seq    = w_head.pc + 32'(INSTR_BYTES);
    w_pred_next   = w_head.taken ? w_head.target : w_head_seq;
    w_actual_next = ex_taken_i ? ex_target_i : w_head_seq;
    w_mispredict  = 1'b0;
    mispredict_o  = 1'b0;
    redirect_pc_o = 32'h0000_0000;
    if (w_resolve && (w_actual_next != w_pred_next)) begin
      w_mispredict  = 1'b1;
      mispredict_o  = 1'b1;
      redirect_pc_o = w_actual_next;
    end else begin
      w_mispredict  = 1'b0;
    end
  end

  // Fetch PC: redirect beats a same-cycle accept; stalls hold the PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_mispredict) begin
      r_pc <= w_actual_next;
    end else if (w_accept) begin
      r_pc <= predict_taken_i ? predict_target_i : (r_pc + 32'(INSTR_BYTES));
    end else begin
      r_pc <= r_pc;
    end
  end

`ifdef FETCH_PC_CHECK_EN
  logic r_err;

  // Sticky flag for a resolution with nothing queued or with the wrong PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (ex_valid_i && (w_empty || (ex_pc_i != w_head.pc))) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_ex_pc;

  assign w_unused_ex_pc = ^ex_pc_i;
  assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench: queue-based reference model checked every cycle plus directed literals.
module tb_fetch_pc_gen;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f_o;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic        predict_taken_i;
  logic [31:0] predict_target_i;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [2:0]  pred_count_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef FETCH_PC_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  fetch_pc_gen dut (
    .clk              (clk),
    .rst              (rst),
    .pc_f_o           (pc_f_o),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_ready_i    (fetch_ready_i),
    .predict_taken_i  (predict_taken_i),
    .predict_target_i (predict_target_i),
    .ex_valid_i       (ex_valid_i),
    .ex_pc_i          (ex_pc_i),
    .ex_taken_i       (ex_taken_i),
    .ex_target_i      (ex_target_i),
    .mispredict_o     (mispredict_o),
    .redirect_pc_o    (redirect_pc_o),
    .pred_count_o     (pred_count_o),
    .err_o            (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue of predictions and a fetch PC.
  rec_t        mq[$];
  logic [31:0] m_pc  = 32'h0;
  logic        m_err = 1'b0;

  always @(negedge clk) begin
    logic [31:0] act_next;
    logic [31:0] pred_next;
    logic        e_mis;
    logic [31:0] e_red;
    logic        e_valid;
    rec_t        r;
    if (rst) begin
      mq.delete();
      m_pc  = 32'h0;
      m_err = 1'b0;
    end else begin
      e_valid  = (mq.size() < 4);
      e_mis    = 1'b0;
      e_red    = 32'h0;
      act_next = 32'h0;
      if (ex_valid_i && mq.size() > 0) begin
        act_next  = ex_taken_i ? ex_target_i : mq[0].pc + 32'd4;
        pred_next = mq[0].taken ? mq[0].target : mq[0].pc + 32'd4;
        if (act_next != pred_next) begin
          e_mis = 1'b1;
          e_red = act_next;
        end
      end
      chk("model_pc", pc_f_o, m_pc);
      chk("model_valid", {31'd0, fetch_valid_o}, {31'd0, e_valid});
      chk("model_count", {29'd0, pred_count_o}, mq.size());
      chk("model_mispredict", {31'd0, mispredict_o}, {31'd0, e_mis});
      chk("model_redirect", redirect_pc_o, e_red);
      chk("model_err", {31'd0, err_o}, {31'd0, m_err & ERR_EN});
      if (ex_valid_i && (mq.size() == 0 || ex_pc_i != mq[0].pc)) m_err = 1'b1;
      if (e_mis) begin
        mq.delete();
        m_pc = act_next;
      end else begin
        if (ex_valid_i && mq.size() > 0) void'(mq.pop_front());
        if (e_valid && fetch_ready_i) begin
          r.pc = m_pc; r.taken = predict_taken_i; r.target = predict_target_i;
          mq.push_back(r);
          m_pc = predict_taken_i ? predict_target_i : m_pc + 32'd4;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_ready_i = 1'b0; predict_taken_i = 1'b0; predict_target_i = 32'h0;
    ex_valid_i = 1'b0; ex_pc_i = 32'h0; ex_taken_i = 1'b0; ex_target_i = 32'h0;
    cyc(); cyc();
    rst = 1'b0; #1;
    chk("rst_pc", pc_f_o, 32'h0);
    chk("rst_count", {29'd0, pred_count_o}, 32'd0);
    chk("rst_valid", {31'd0, fetch_valid_o}, 32'd1);
    chk("rst_mispredict", {31'd0, mispredict_o}, 32'd0);
    chk("rst_redirect", redirect_pc_o, 32'h0);
    chk("rst_err", {31'd0, err_o}, 32'd0);

    fetch_ready_i = 1'b1;
    cyc(); chk("seq_pc4", pc_f_o, 32'h4);
    cyc(); chk("seq_pc8", pc_f_o, 32'h8);
    cyc(); chk("seq_pcC", pc_f_o, 32'hC);
    chk("seq_count3", {29'd0, pred_count_o}, 32'd3);

    predict_taken_i = 1'b1; predict_target_i = 32'h40;
    cyc(); chk("taken_pc40", pc_f_o, 32'h40);
    chk("full_valid0", {31'd0, fetch_valid_o}, 32'd0);
    predict_taken_i = 1'b0;
    cyc(); chk("full_pc_hold", pc_f_o, 32'h40);

    ex_valid_i = 1'b1; ex_pc_i = 32'h0; ex_taken_i = 1'b0; #1;
    chk("pop_nt_ok", {31'd0, mispredict_o}, 32'd0);
    cyc();
    chk("pop_frees_valid1", {31'd0, fetch_valid_o}, 32'd1);
    chk("pop_count3", {29'd0, pred_count_o}, 32'd3);
    ex_pc_i = 32'h4;
    cyc(); ex_pc_i = 32'h8;
    cyc(); chk("accept_pop_pc48", pc_f_o, 32'h48);
    chk("accept_pop_count3", {29'd0, pred_count_o}, 32'd3);

    fetch_ready_i = 1'b0; ex_pc_i = 32'hC; ex_taken_i = 1'b1; ex_target_i = 32'h40; #1;
    chk("taken_ok", {31'd0, mispredict_o}, 32'd0);
    cyc();

    fetch_ready_i = 1'b1; ex_pc_i = 32'h40; ex_taken_i = 1'b1; ex_target_i = 32'h80; #1;
    chk("dir_mispredict", {31'd0, mispredict_o}, 32'd1);
    chk("dir_redirect", redirect_pc_o, 32'h80);
    cyc(); ex_valid_i = 1'b0;
    chk("dir_pc80", pc_f_o, 32'h80);
    chk("dir_count0", {29'd0, pred_count_o}, 32'd0);

    predict_taken_i = 1'b1; predict_target_i = 32'h100;
    cyc(); predict_taken_i = 1'b0; fetch_ready_i = 1'b0;
    ex_valid_i = 1'b1; ex_pc_i = 32'h80; ex_taken_i = 1'b1; ex_target_i = 32'h104; #1;
    chk("tgt_mispredict", {31'd0, mispredict_o}, 32'd1);
    chk("tgt_redirect", redirect_pc_o, 32'h104);
    cyc(); ex_valid_i = 1'b0;
    chk("tgt_pc104", pc_f_o, 32'h104);

    fetch_ready_i = 1'b1; predict_taken_i = 1'b1; predict_target_i = 32'hFFFF_FFFC;
    cyc(); chk("wrap_pre", pc_f_o, 32'hFFFF_FFFC);
    predict_taken_i = 1'b0;
    cyc(); chk("wrap_pc0", pc_f_o, 32'h0);
    fetch_ready_i = 1'b0;

    ex_valid_i = 1'b1; ex_pc_i = 32'h104; ex_taken_i = 1'b1; ex_target_i = 32'hFFFF_FFFC;
    cyc(); ex_pc_i = 32'hFFFF_FFFC; ex_taken_i = 1'b0; #1;
    chk("wrap_resolve_ok", {31'd0, mispredict_o}, 32'd0);
    cyc(); chk("drain_count0", {29'd0, pred_count_o}, 32'd0);
    ex_pc_i = 32'h0; #1;
    chk("empty_no_mispredict", {31'd0, mispredict_o}, 32'd0);
    cyc(); ex_valid_i = 1'b0;
    chk("empty_count0", {29'd0, pred_count_o}, 32'd0);
    chk("empty_err", {31'd0, err_o}, {31'd0, ERR_EN});
    cyc(); cyc();
    chk("err_sticky", {31'd0, err_o}, {31'd0, ERR_EN});

    fetch_ready_i = 1'b1;
    cyc(); cyc();
    rst = 1'b1;
    cyc(); rst = 1'b0; #1;
    chk("midrst_pc", pc_f_o, 32'h0);
    chk("midrst_count", {29'd0, pred_count_o}, 32'd0);
    chk("midrst_err", {31'd0, err_o}, 32'd0);
    cyc(); cyc(); fetch_ready_i = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
